// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, ExcCodes, Status/Cause bit positions
// and the per-cycle commit event used to arbitrate register updates.
package cp0_regfile_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;
  localparam int CAUSE_TI_BIT   = 30;
  localparam int CAUSE_BD_BIT   = 31;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_EX   = 2'd1,
    EV_ERET = 2'd2,
    EV_MTC0 = 2'd3
  } cp0_event_e;

  function automatic logic is_addr_exc(input logic [4:0] excode);
    return (excode == EXC_ADEL) || (excode == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: divided Count, Compare and the sticky timer interrupt TI.
// Instantiated by cp0_regfile only when CP0_TIMER_EN is defined.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        we_count,
  input  logic        we_compare,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic        r_phase;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;
  logic        w_tick;

  assign w_tick = (COUNT_DIV == 1) ? 1'b1 : r_phase;

  // A Count write beats the increment; a Compare write beats a same-edge TI set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_phase   <= 1'b0;
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_ti      <= 1'b0;
    end else begin
      r_phase <= (COUNT_DIV == 1) ? 1'b0 : ~r_phase;
      if (we_count) begin
        r_count <= wdata;
      end else if (w_tick) begin
        r_count <= r_count + 32'd1;
      end
      if (we_compare) begin
        r_compare <= wdata;
      end
      if (we_compare) begin
        r_ti <= 1'b0;
      end else if (w_tick && (r_count == r_compare)) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign count   = r_count;
  assign compare = r_compare;
  assign ti      = r_ti;

endmodule

// File: rtl/cp0_regfile.sv
// MIPS CP0 register file for the WB stage (BadVAddr, Count, Compare, Status, Cause, EPC).
// Define CP0_TIMER_EN to implement Count/Compare and the timer interrupt.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter logic [31:0] STATUS_RST = 32'h0040_0000,
  parameter int          COUNT_DIV  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic        wb_ex,
  input  logic [4:0]  wb_excode,
  input  logic        wb_bd,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_badvaddr,
  input  logic        wb_eret,
  input  logic [5:0]  hw_int,
  output logic [31:0] cp0_epc,
  output logic        cp0_status_exl,
  output logic        int_pending
);

  if ((COUNT_DIV != 1) && (COUNT_DIV != 2)) begin : g_bad_div
    $error("cp0_regfile: COUNT_DIV must be 1 or 2");
  end

  logic [7:0]  r_status_im;
  logic        r_status_exl;
  logic        r_status_ie;
  logic        r_cause_bd;
  logic [4:0]  r_cause_exc;
  logic [1:0]  r_cause_ip_sw;
  logic [5:0]  r_hw_ip;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic        r_int_pending;

  cp0_event_e  w_ev;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ti;
  logic [7:0]  w_cause_ip;
  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic [31:0] w_rdata;

  // Only the highest-priority commit of the cycle takes effect.
  always_comb begin
    if (wb_ex) begin
      w_ev = EV_EX;
    end else if (wb_eret) begin
      w_ev = EV_ERET;
    end else if (mtc0_we) begin
      w_ev = EV_MTC0;
    end else begin
      w_ev = EV_NONE;
    end
  end

`ifdef CP0_TIMER_EN
  logic w_we_count;
  logic w_we_compare;

  assign w_we_count   = (w_ev == EV_MTC0) && (cp0_addr == CP0_COUNT);
  assign w_we_compare = (w_ev == EV_MTC0) && (cp0_addr == CP0_COMPARE);

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .we_count   (w_we_count),
    .we_compare (w_we_compare),
    .wdata      (cp0_wdata),
    .count      (w_count),
    .compare    (w_compare),
    .ti         (w_ti)
  );
`else
  assign w_count   = 32'd0;
  assign w_compare = 32'd0;
  assign w_ti      = 1'b0;
`endif

  assign w_cause_ip = {r_hw_ip[5] | w_ti, r_hw_ip[4:0], r_cause_ip_sw};
  assign w_status   = {STATUS_RST[31:16], r_status_im, STATUS_RST[7:2], r_status_exl, r_status_ie};
  assign w_cause    = {r_cause_bd, w_ti, 14'd0, w_cause_ip, 1'b0, r_cause_exc, 2'b00};

  // CP0 state update; EPC/BD are frozen while already at exception level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_status_im   <= STATUS_RST[15:8];
      r_status_exl  <= STATUS_RST[STATUS_EXL_BIT];
      r_status_ie   <= STATUS_RST[STATUS_IE_BIT];
      r_cause_bd    <= 1'b0;
      r_cause_exc   <= EXC_INT;
      r_cause_ip_sw <= 2'b00;
      r_hw_ip       <= 6'd0;
      r_epc         <= 32'd0;
      r_badvaddr    <= 32'd0;
      r_int_pending <= 1'b0;
    end else begin
      r_hw_ip       <= hw_int;
      r_int_pending <= r_status_ie & ~r_status_exl & (|(r_status_im & w_cause_ip));
      case (w_ev)
        EV_EX: begin
          r_cause_exc  <= wb_excode;
          r_status_exl <= 1'b1;
          if (!r_status_exl) begin
            r_epc      <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
            r_cause_bd <= wb_bd;
          end
          if (is_addr_exc(wb_excode)) begin
            r_badvaddr <= wb_badvaddr;
          end
        end
        EV_ERET: begin
          r_status_exl <= 1'b0;
        end
        EV_MTC0: begin
          case (cp0_addr)
            CP0_STATUS: begin
              r_status_im  <= cp0_wdata[15:8];
              r_status_exl <= cp0_wdata[STATUS_EXL_BIT];
              r_status_ie  <= cp0_wdata[STATUS_IE_BIT];
            end
            CP0_CAUSE: r_cause_ip_sw <= cp0_wdata[9:8];
            CP0_EPC:   r_epc         <= cp0_wdata;
            default:   ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // mfc0 read mux; reads see pre-commit state.
  always_comb begin
    w_rdata = 32'd0;
    case (cp0_addr)
      CP0_BADVADDR: w_rdata = r_badvaddr;
      CP0_COUNT:    w_rdata = w_count;
      CP0_COMPARE:  w_rdata = w_compare;
      CP0_STATUS:   w_rdata = w_status;
      CP0_CAUSE:    w_rdata = w_cause;
      CP0_EPC:      w_rdata = r_epc;
      default:      w_rdata = 32'd0;
    endcase
  end

  assign cp0_rdata      = w_rdata;
  assign cp0_epc        = r_epc;
  assign cp0_status_exl = r_status_exl;
  assign int_pending    = r_int_pending;

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios plus randomized commits
// checked against a register-level reference model.
module tb_cp0_regfile;

  logic        clk;
  logic        resetn;
  logic        mtc0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        wb_ex;
  logic [4:0]  wb_excode;
  logic        wb_bd;
  logic [31:0] wb_pc;
  logic [31:0] wb_badvaddr;
  logic        wb_eret;
  logic [5:0]  hw_int;
  logic [31:0] cp0_epc;
  logic        cp0_status_exl;
  logic        int_pending;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_status, m_cause, m_epc, m_badv;
  logic        m_pend;

  cp0_regfile #(
    .STATUS_RST (32'h0040_0000),
    .COUNT_DIV  (2)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .mtc0_we        (mtc0_we),
    .cp0_addr       (cp0_addr),
    .cp0_wdata      (cp0_wdata),
    .cp0_rdata      (cp0_rdata),
    .wb_ex          (wb_ex),
    .wb_excode      (wb_excode),
    .wb_bd          (wb_bd),
    .wb_pc          (wb_pc),
    .wb_badvaddr    (wb_badvaddr),
    .wb_eret        (wb_eret),
    .hw_int         (hw_int),
    .cp0_epc        (cp0_epc),
    .cp0_status_exl (cp0_status_exl),
    .int_pending    (int_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  // With the timer built in, Count/Compare/TI evolve on their own; those bits are checked in test_timer.
  function automatic logic [31:0] rd_mask(input logic [4:0] a);
`ifdef CP0_TIMER_EN
    if (a == 5'd9 || a == 5'd11) return 32'd0;
    if (a == 5'd13) return 32'hBFFF_7FFF;
`endif
    return 32'hFFFF_FFFF;
  endfunction

  task automatic model_reset();
    m_status = 32'h0040_0000;
    m_cause  = 32'd0;
    m_epc    = 32'd0;
    m_badv   = 32'd0;
    m_pend   = 1'b0;
  endtask

  task automatic clear_inputs();
    mtc0_we = 1'b0; cp0_addr = 5'd0; cp0_wdata = 32'd0;
    wb_ex = 1'b0; wb_excode = 5'd0; wb_bd = 1'b0; wb_pc = 32'd0;
    wb_badvaddr = 32'd0; wb_eret = 1'b0;
  endtask

  // Apply this cycle's commit to the model, then clock the DUT.
  task automatic tick();
    logic pend_n;
    pend_n = m_status[0] & ~m_status[1] & (|(m_status[15:8] & m_cause[15:8]));
    if (wb_ex) begin
      m_cause[6:2] = wb_excode;
      if (!m_status[1]) begin
        m_epc = wb_bd ? wb_pc - 32'd4 : wb_pc;
        m_cause[31] = wb_bd;
      end
      m_status[1] = 1'b1;
      if (wb_excode == 5'd4 || wb_excode == 5'd5) m_badv = wb_badvaddr;
    end else if (wb_eret) begin
      m_status[1] = 1'b0;
    end else if (mtc0_we) begin
      case (cp0_addr)
        5'd12:   m_status = (m_status & ~32'h0000_FF03) | (cp0_wdata & 32'h0000_FF03);
        5'd13:   m_cause  = (m_cause & ~32'h0000_0300) | (cp0_wdata & 32'h0000_0300);
        5'd14:   m_epc    = cp0_wdata;
        default: ;
      endcase
    end
    m_cause[15:10] = hw_int;
    @(posedge clk);
    #1;
    m_pend = pend_n;
    wb_ex = 1'b0; wb_eret = 1'b0; mtc0_we = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    hw_int = 6'd0;
    resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    n_checks++;
    if (cp0_epc !== 32'd0 || cp0_status_exl !== 1'b0 || int_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: epc=%h exl=%b pend=%b, required 0/0/0", cp0_epc, cp0_status_exl, int_pending);
    end
    for (int a = 0; a < 32; a++) begin
      cp0_addr = a[4:0];
      #1;
      n_checks++;
      if ((cp0_rdata & rd_mask(a[4:0])) !== (m_rd(a[4:0]) & rd_mask(a[4:0]))) begin
        n_fail++;
        $display("FAIL reset_read[%0d]: got %h, required %h", a, cp0_rdata, m_rd(a[4:0]));
      end
    end
  endtask

  task automatic test_exception_eret();
    wb_ex = 1'b1; wb_excode = 5'd12; wb_pc = 32'hBFC0_1000; wb_bd = 1'b0;
    tick();
    cp0_addr = 5'd13; #1;
    n_checks++;
    if (cp0_epc !== 32'hBFC0_1000 || cp0_status_exl !== 1'b1 || cp0_rdata[6:2] !== 5'd12) begin
      n_fail++;
      $display("FAIL ex_commit: epc=%h exl=%b exc=%0d, required bfc01000/1/12", cp0_epc, cp0_status_exl, cp0_rdata[6:2]);
    end
    wb_eret = 1'b1;
    tick();
    cp0_addr = 5'd14; #1;
    n_checks++;
    if (cp0_status_exl !== 1'b0 || cp0_rdata !== m_epc || cp0_epc !== 32'hBFC0_1000) begin
      n_fail++;
      $display("FAIL eret: exl=%b epc=%h rd=%h, required 0/bfc01000", cp0_status_exl, cp0_epc, cp0_rdata);
    end
  endtask

  task automatic test_bd_nested();
    wb_ex = 1'b1; wb_bd = 1'b1; wb_pc = 32'h8000_0010; wb_excode = 5'd4; wb_badvaddr = 32'h1;
    tick();
    cp0_addr = 5'd8; #1;
    n_checks++;
    if (cp0_epc !== 32'h8000_000C || cp0_rdata !== 32'h1) begin
      n_fail++;
      $display("FAIL bd_ex: epc=%h badv=%h, required 8000000c/1", cp0_epc, cp0_rdata);
    end
    cp0_addr = 5'd13; #1;
    n_checks++;
    if (cp0_rdata[31] !== 1'b1 || (cp0_rdata & rd_mask(5'd13)) !== (m_cause & rd_mask(5'd13))) begin
      n_fail++;
      $display("FAIL bd_cause: got %h, required %h", cp0_rdata, m_cause);
    end
    wb_ex = 1'b1; wb_bd = 1'b0; wb_pc = 32'h0; wb_excode = 5'd10; wb_badvaddr = 32'h55;
    tick();
    cp0_addr = 5'd13; #1;
    n_checks++;
    if (cp0_epc !== 32'h8000_000C || cp0_rdata[6:2] !== 5'd10 || cp0_rdata[31] !== 1'b1) begin
      n_fail++;
      $display("FAIL nested_ex: epc=%h cause=%h, required epc 8000000c exc 10 bd 1", cp0_epc, cp0_rdata);
    end
    cp0_addr = 5'd8; #1;
    n_checks++;
    if (cp0_rdata !== 32'h1) begin
      n_fail++;
      $display("FAIL nested_badv: got %h, required 00000001", cp0_rdata);
    end
    wb_eret = 1'b1;
    tick();
  endtask

  task automatic test_priority();
    wb_ex = 1'b1; wb_eret = 1'b1; mtc0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h1234;
    wb_excode = 5'd8; wb_pc = 32'h0040_0100; wb_bd = 1'b0;
    tick();
    n_checks++;
    if (cp0_status_exl !== 1'b1 || cp0_epc !== 32'h0040_0100) begin
      n_fail++;
      $display("FAIL priority: exl=%b epc=%h, required 1/00400100", cp0_status_exl, cp0_epc);
    end
    wb_eret = 1'b1; mtc0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'hABCD;
    tick();
    n_checks++;
    if (cp0_status_exl !== 1'b0 || cp0_epc !== 32'h0040_0100) begin
      n_fail++;
      $display("FAIL eret_over_mtc0: exl=%b epc=%h, required 0/00400100", cp0_status_exl, cp0_epc);
    end
  endtask

  task automatic test_interrupt();
    mtc0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401; hw_int = 6'b000001;
    tick();
    tick();
    n_checks++;
    if (int_pending !== 1'b1 || int_pending !== m_pend) begin
      n_fail++;
      $display("FAIL int_pending_set: got %b, required 1", int_pending);
    end
    mtc0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0403;
    tick();
    tick();
    n_checks++;
    if (int_pending !== 1'b0 || cp0_status_exl !== 1'b1) begin
      n_fail++;
      $display("FAIL int_masked_exl: pend=%b exl=%b, required 0/1", int_pending, cp0_status_exl);
    end
    hw_int = 6'd0;
    mtc0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0000;
    tick();
  endtask

  task automatic test_reset_mid();
    wb_ex = 1'b1; wb_excode = 5'd5; wb_pc = 32'h1000_0000; wb_badvaddr = 32'hDEAD_BEEF;
    @(negedge clk);
    resetn = 1'b0;
    model_reset();
    #1;
    cp0_addr = 5'd12; #1;
    n_checks++;
    if (cp0_status_exl !== 1'b0 || cp0_epc !== 32'd0 || cp0_rdata !== 32'h0040_0000) begin
      n_fail++;
      $display("FAIL reset_mid: exl=%b epc=%h status=%h, required 0/0/00400000", cp0_status_exl, cp0_epc, cp0_rdata);
    end
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    resetn = 1'b1;
    cp0_addr = 5'd8; #1;
    n_checks++;
    if (cp0_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_badv: got %h, required 0", cp0_rdata);
    end
  endtask

`ifdef CP0_TIMER_EN
  task automatic test_timer();
    bit seen;
    mtc0_we = 1'b1; cp0_addr = 5'd9; cp0_wdata = 32'd0;
    tick();
    mtc0_we = 1'b1; cp0_addr = 5'd11; cp0_wdata = 32'd5;
    tick();
    cp0_addr = 5'd13; #1;
    n_checks++;
    if (cp0_rdata[30] !== 1'b0) begin
      n_fail++;
      $display("FAIL ti_clear_on_compare: got %b, required 0", cp0_rdata[30]);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      cp0_addr = 5'd13; #1;
      seen = cp0_rdata[30];
    end
    cp0_addr = 5'd9; #1;
    n_checks++;
    if (!seen || cp0_rdata < 32'd5 || cp0_rdata > 32'd7) begin
      n_fail++;
      $display("FAIL ti_set: seen=%b count=%0d, required TI=1 with count 5..7", seen, cp0_rdata);
    end
    mtc0_we = 1'b1; cp0_addr = 5'd11; cp0_wdata = 32'd100;
    tick();
    cp0_addr = 5'd13; #1;
    n_checks++;
    if (cp0_rdata[30] !== 1'b0) begin
      n_fail++;
      $display("FAIL ti_cleared: got %b, required 0", cp0_rdata[30]);
    end
    mtc0_we = 1'b1; cp0_addr = 5'd9; cp0_wdata = 32'hFFFF_FFFF;
    tick();
    cp0_addr = 5'd9; #1;
    for (int i = 0; i < 4 && cp0_rdata == 32'hFFFF_FFFF; i++) begin
      tick();
      cp0_addr = 5'd9; #1;
    end
    n_checks++;
    if (cp0_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL count_wrap: got %h, required 00000000", cp0_rdata);
    end
  endtask
`endif

  task automatic test_random();
    logic [4:0] addr_tab [8];
    logic [4:0] excode_tab [7];
    logic [4:0] a;
    addr_tab   = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3, 5'd20};
    excode_tab = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};
    for (int i = 0; i < 300; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (i % 8 == 0) hw_int = 6'($urandom);
      wb_ex   = (sel < 2);
      wb_eret = (sel == 2 || sel == 3) || ($urandom_range(0, 7) == 0);
      mtc0_we = (sel >= 3);
      cp0_addr    = addr_tab[$urandom_range(0, 7)];
      cp0_wdata   = $urandom;
      wb_excode   = excode_tab[$urandom_range(0, 6)];
      wb_bd       = 1'($urandom);
      wb_pc       = $urandom & 32'hFFFF_FFFC;
      wb_badvaddr = $urandom;
`ifdef CP0_TIMER_EN
      if (cp0_addr == 5'd9 || cp0_addr == 5'd11) cp0_addr = 5'd13;
      cp0_wdata[15] = 1'b0;
`endif
      tick();
      n_checks++;
      if (cp0_epc !== m_epc || cp0_status_exl !== m_status[1] || int_pending !== m_pend) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: epc=%h exl=%b pend=%b, required %h/%b/%b",
                 i, cp0_epc, cp0_status_exl, int_pending, m_epc, m_status[1], m_pend);
      end
      a = addr_tab[$urandom_range(0, 7)];
      cp0_addr = a; #1;
      n_checks++;
      if ((cp0_rdata & rd_mask(a)) !== (m_rd(a) & rd_mask(a))) begin
        n_fail++;
        $display("FAIL rand_read[%0d] addr %0d: got %h, required %h", i, a, cp0_rdata, m_rd(a));
      end
    end
  endtask

  initial begin
    test_reset();
    test_exception_eret();
    test_bd_nested();
    test_priority();
    test_interrupt();
`ifdef CP0_TIMER_EN
    test_timer();
`endif
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
